// File: rtl/multiword_add_pkg.sv
// Shared types and sizing helpers for the sequential multi-word adder.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SLICE = 4;

  // Guarded against SLICE<1 so the bad-parameter error can be reported cleanly.
  function automatic int calc_nslice(input int width, input int slice);
    return (slice < 1) ? 1 : width / slice;
  endfunction

  function automatic int calc_idx_w(input int nslice);
    return (nslice <= 2) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/multiword_add_seq_add_slice.sv
// Combinational W-bit ripple-carry adder slice, shared across all slice cycles.
module add_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  always_comb begin
    logic [W:0] c;
    c      = '0;
    sum_o  = '0;
    c[0]   = cin_i;
    for (int i = 0; i < W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[W];
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-cycle WIDTH-bit adder reusing one SLICE-bit slice, LSB slice first.
// Optional subtract mode with signed overflow flag: define MULTIWORD_ADD_SEQ_SUB_EN.
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  if (SLICE < 1) begin : g_bad_slice
    $error("multiword_add_seq: SLICE must be >= 1");
  end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("multiword_add_seq: WIDTH must be a multiple of SLICE");
  end

  localparam int NSLICE = calc_nslice(WIDTH, SLICE);
  localparam int IDXW   = calc_idx_w(NSLICE);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  logic             ovf_q, ovf_d;
`endif

  int               slice_lsb;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] b_accept;
  logic             carry_accept;

  assign slice_lsb = int'(idx_q) * SLICE;

  // Subtraction is a + ~b + 1, so the inversion happens once, at accept time.
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  assign b_accept     = sub ? ~b : b;
  assign carry_accept = sub ? 1'b1 : cin;
`else
  assign b_accept     = b;
  assign carry_accept = cin;
`endif

  add_slice #(
    .W(SLICE)
  ) u_add_slice (
    .a_i    (a_q[slice_lsb +: SLICE]),
    .b_i    (b_q[slice_lsb +: SLICE]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    // NOTE: every _d defaults to its _q (and every output to 0) first, so no path infers a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b_accept;
          carry_d = carry_accept;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        busy                        = 1'b1;
        sum_d[slice_lsb +: SLICE]   = slice_sum;
        carry_d                     = slice_cout;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = slice_cout;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slice_sum[SLICE-1] != a_q[WIDTH-1]);
`endif
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
  assign ovf  = ovf_q;
`endif

endmodule
